text_scanout: RTL and testbench
===============================

Name: text_scanout

Overview:
- Downstream consumer of video_ram's read port, in the same `clk` domain.
- Generates raster timing and walks the character grid, driving `read_ad` once per pixel.
- Takes the returned 9-bit cell word and re-times it with sync, blanking and in-cell pixel coordinates.
- Output feeds the glyph/colour stage. All outputs are aligned to the RAM read latency.

Parameters:
H_ACTIVE, 512, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 64, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 256, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
RD_LAT, 2, read_ad-to-read_data latency of video_ram in pipeline read mode (valid range 1..4)

Ports:
clk  in  1  pixel clock; same clock as video_ram read port
reset  in  1  asynchronous, active-low reset
read_ad  out  11  cell address to video_ram
read_data  in  9  cell word from video_ram, valid RD_LAT cycles after read_ad
hsync  out  1  horizontal sync, aligned with cell_data
vsync  out  1  vertical sync, aligned with cell_data
de  out  1  display enable (visible pixel), aligned
in_text  out  1  pixel lies inside the 64x32 cell grid; cell_data meaningful
cell_data  out  9  cell word for this pixel; 0 when in_text=0
px_x  out  3  column within cell (0..7)
px_y  out  3  line within cell (0..7)
frame_start  out  1  one-cycle pulse, aligned with pixel (0,0)

Behaviour:
- Geometry:
  - H_TOTAL = sum of the four H parameters; V_TOTAL likewise.
  - hcnt runs 0..H_TOTAL-1 and wraps to 0, which increments vcnt.
  - vcnt runs 0..V_TOTAL-1 and wraps to 0 when hcnt wraps at its maximum.
- Stage-0 decode (combinational from the counters):
  - de0 = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - hs0 is asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; vs0 likewise on vcnt.
- Cell mapping: 8x8-pixel cells on a 64-column x 32-row grid.
  - col = hcnt[8:3], row = vcnt[7:3].
  - in_text0 = de0 && hcnt<512 && vcnt<256.
  - When in_text0: read_ad = {row, col}, i.e. row*64+col.
  - Otherwise read_ad is driven to 0.
  - read_ad is registered (driven from the stage-0 flop).
- Alignment:
  - de, hsync, vsync, in_text, px_x=hcnt[2:0], px_y=vcnt[2:0] and frame_start pass through a shift pipeline of depth RD_LAT+1.
  - Depth = 1 for the read_ad register plus RD_LAT for the RAM.
  - So the control outputs for a pixel appear in the same cycle as the read_data produced for that pixel's read_ad.
- Output gating:
  - cell_data = read_data when the aligned in_text=1; else 0.
  - cell_data is combinational from read_data and the pipeline bit; it is not re-registered.
- frame_start: asserted at stage 0 when hcnt==0 && vcnt==0, then delayed like the other controls.
- Sync polarity: hsync/vsync output = active ^ ~SYNC_POL. Active level equals SYNC_POL.
- Reset (async, reset=0):
  - Counters, read_ad and all pipeline stages go to 0.
  - hsync/vsync go to their inactive level.
  - de, in_text, frame_start, px_x, px_y are 0.
- Reset release:
  - The first rising edge after deassertion presents hcnt=0, vcnt=0.
  - frame_start appears RD_LAT+1 cycles later.
- Reset mid-frame: the frame is abandoned, with no partial flush; the raster restarts from (0,0).
- Grid edges:
  - Pixels with hcnt>=512 or vcnt>=256 that still have de=1 (when H_ACTIVE>512 or V_ACTIVE>256) output in_text=0 and cell_data=0.
  - If H_ACTIVE<512, columns beyond H_ACTIVE are never fetched.
- read_ad never exceeds 2047; no arithmetic overflow is possible given the 6/5-bit col/row slices.

Test Plan:
- Reset and first frame, small timing (H: 16/2/2/2, V: 4/1/1/1, RD_LAT=2, SYNC_POL=0): hold reset low 5 cycles, release -> frame_start high exactly 3 cycles after the first edge; hsync low at hcnt 18..19 delayed by 3; H_TOTAL=22, V_TOTAL=7.
- Address walk, same timing: check read_ad sequence across line 0 -> 0 x8, then 1 x8, then 0 through blanking; on line 3 (row 0) -> the same values; with V_ACTIVE=16 and line 8 -> 64 x8, 65 x8.
- Data alignment with a RAM model returning read_data = {read_ad[8:0]} after 2 cycles -> cell_data equals the address of the pixel's cell and px_x counts 0..7 in lockstep; cell_data=0 whenever de=0.
- Grid overflow, H_ACTIVE=520: pixels hcnt 512..519 -> de=1, in_text=0, cell_data=0, read_ad=0.
- Last cell: with V_ACTIVE=256, H_ACTIVE=512 -> the last visible pixel fetches read_ad=2047; wrap to (0,0) produces frame_start again after exactly H_TOTAL*V_TOTAL cycles.
- Mid-frame reset: assert reset at vcnt=100 for one cycle -> all outputs drop to reset values immediately (async); after release, frame_start pulses again at RD_LAT+1 cycles; SYNC_POL=1 run inverts hsync/vsync levels only.

Source files
------------

// File: rtl/text_scanout.sv
// Raster timing generator and character-grid walker feeding video_ram reads; re-times cell words with sync/blank/pixel coords.
// Latency: read_ad is one register after the counters; all other outputs are RD_LAT+1 cycles after the counters.
// Backpressure: none; free-running pixel-rate stream, the downstream stage must accept one pixel per clock.
module text_scanout #(
   parameter int H_ACTIVE = 512,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 64,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 256,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0,
   parameter int RD_LAT   = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [10:0] read_ad,
   input  logic [8:0]  read_data,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        in_text,
   output logic [8:0]  cell_data,
   output logic [2:0]  px_x,
   output logic [2:0]  px_y,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Counters are at least wide enough to slice col = hcnt[8:3] and row = vcnt[7:3]
   // and to compare against the 512x256 grid limits, even for tiny test timings.
   localparam int HW = ($clog2(H_TOTAL + 1) > 10) ? $clog2(H_TOTAL + 1) : 10;
   localparam int VW = ($clog2(V_TOTAL + 1) > 9) ? $clog2(V_TOTAL + 1) : 9;

   localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_GRID = HW'(512);
   localparam logic [HW-1:0] H_ONE  = HW'(1);

   localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_GRID = VW'(256);
   localparam logic [VW-1:0] V_ONE  = VW'(1);

   localparam logic POL = (SYNC_POL != 0);

   // Per-pixel control word carried alongside the RAM read. Sync bits are
   // stored as "active" and converted to the output polarity at the end.
   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic       in_text;
      logic       fs;
      logic [2:0] px;
      logic [2:0] py;
   } ctrl_t;

   logic [HW-1:0]      hcnt_q, hcnt_d;
   logic [VW-1:0]      vcnt_q, vcnt_d;
   logic [10:0]        read_ad_q, read_ad_d;
   ctrl_t              ctrl0;
   ctrl_t [RD_LAT:0]   pipe_q, pipe_d;
   ctrl_t              out_c;

   // Raster counters: hcnt wraps at H_TOTAL-1 and carries into vcnt.
   always_comb begin
      hcnt_d = hcnt_q + H_ONE;
      vcnt_d = vcnt_q;
      if (hcnt_q == H_MAX) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == V_MAX) ? '0 : vcnt_q + V_ONE;
      end
   end

   // Stage-0 decode of the current raster position and the cell address to fetch.
   always_comb begin
      ctrl0         = '0;
      ctrl0.de      = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
      ctrl0.hs      = (hcnt_q >= H_SS) && (hcnt_q < H_SE);
      ctrl0.vs      = (vcnt_q >= V_SS) && (vcnt_q < V_SE);
      ctrl0.in_text = ctrl0.de && (hcnt_q < H_GRID) && (vcnt_q < V_GRID);
      ctrl0.fs      = (hcnt_q == '0) && (vcnt_q == '0);
      ctrl0.px      = hcnt_q[2:0];
      ctrl0.py      = vcnt_q[2:0];
      // Outside the grid the address is parked at 0 so nothing past H_ACTIVE is ever fetched.
      read_ad_d     = ctrl0.in_text ? {vcnt_q[7:3], hcnt_q[8:3]} : 11'd0;
   end

   // Control shift pipeline: slot 0 sits beside read_ad, slot RD_LAT meets read_data.
   always_comb begin
      pipe_d = {pipe_q[RD_LAT-1:0], ctrl0};
   end

   // State registers; a reset anywhere in the frame restarts the raster at (0,0) with an empty pipeline.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hcnt_q    <= '0;
         vcnt_q    <= '0;
         read_ad_q <= '0;
         pipe_q    <= '0;
      end else begin
         hcnt_q    <= hcnt_d;
         vcnt_q    <= vcnt_d;
         read_ad_q <= read_ad_d;
         pipe_q    <= pipe_d;
      end
   end

   assign out_c       = pipe_q[RD_LAT];
   assign read_ad     = read_ad_q;
   assign de          = out_c.de;
   assign in_text     = out_c.in_text;
   assign frame_start = out_c.fs;
   assign px_x        = out_c.px;
   assign px_y        = out_c.py;
   assign hsync       = out_c.hs ^ ~POL;
   assign vsync       = out_c.vs ^ ~POL;
   // read_data arrives in the same cycle as its pixel's control word, so gate it unregistered.
   assign cell_data   = out_c.in_text ? read_data : 9'd0;

endmodule

// File: tb/tb_text_scanout.sv
// Bench for text_scanout: three instances (small timing, grid overflow with
// positive sync, default timing with minimum latency) share clock and reset,
// each fed by a RAM model that returns mem[read_ad] RD_LAT cycles later.
module tb_text_scanout;

   typedef struct {
      int ha; int hf; int hs; int hb;
      int va; int vf; int vs; int vb;
      int pol; int lat;
   } cfg_t;

   typedef struct {
      int ad; int hs; int vs; int de; int it; int fs; int px; int py; int cd;
   } exp_t;

   typedef struct {
      int n; int ad; int hs; int vs; int de; int it; int fs; int px; int py; int cd;
   } vec_t;

   localparam int A_LAT = 2;
   localparam int B_LAT = 3;
   localparam int C_LAT = 1;

   cfg_t cfg_a = '{16, 2, 2, 2, 16, 1, 1, 1, 0, A_LAT};
   cfg_t cfg_b = '{520, 8, 16, 8, 16, 1, 1, 1, 1, B_LAT};
   cfg_t cfg_c = '{512, 16, 64, 48, 256, 10, 2, 33, 0, C_LAT};

   logic clk = 1'b0;
   logic reset;
   logic [8:0] mem [2048];
   int n;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   // Edges since reset release: after edge n the counters have passed pixel n-1.
   always @(posedge clk or negedge reset) begin
      if (!reset) n <= 0;
      else        n <= n + 1;
   end

   logic [10:0] a_read_ad, b_read_ad, c_read_ad;
   logic [8:0]  a_read_data, b_read_data, c_read_data;
   logic [8:0]  a_cell_data, b_cell_data, c_cell_data;
   logic        a_hsync, a_vsync, a_de, a_in_text, a_frame_start;
   logic        b_hsync, b_vsync, b_de, b_in_text, b_frame_start;
   logic        c_hsync, c_vsync, c_de, c_in_text, c_frame_start;
   logic [2:0]  a_px_x, a_px_y, b_px_x, b_px_y, c_px_x, c_px_y;

   text_scanout #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
                  .V_ACTIVE(16), .V_FP(1), .V_SYNC(1), .V_BP(1),
                  .SYNC_POL(0), .RD_LAT(A_LAT)) u_a (
      .clk(clk), .reset(reset), .read_ad(a_read_ad), .read_data(a_read_data),
      .hsync(a_hsync), .vsync(a_vsync), .de(a_de), .in_text(a_in_text),
      .cell_data(a_cell_data), .px_x(a_px_x), .px_y(a_px_y), .frame_start(a_frame_start));

   text_scanout #(.H_ACTIVE(520), .H_FP(8), .H_SYNC(16), .H_BP(8),
                  .V_ACTIVE(16), .V_FP(1), .V_SYNC(1), .V_BP(1),
                  .SYNC_POL(1), .RD_LAT(B_LAT)) u_b (
      .clk(clk), .reset(reset), .read_ad(b_read_ad), .read_data(b_read_data),
      .hsync(b_hsync), .vsync(b_vsync), .de(b_de), .in_text(b_in_text),
      .cell_data(b_cell_data), .px_x(b_px_x), .px_y(b_px_y), .frame_start(b_frame_start));

   text_scanout #(.RD_LAT(C_LAT)) u_c (
      .clk(clk), .reset(reset), .read_ad(c_read_ad), .read_data(c_read_data),
      .hsync(c_hsync), .vsync(c_vsync), .de(c_de), .in_text(c_in_text),
      .cell_data(c_cell_data), .px_x(c_px_x), .px_y(c_px_y), .frame_start(c_frame_start));

   // RAM models: address pipelines, data tapped after each instance's latency.
   logic [10:0] a_rp [4];
   logic [10:0] b_rp [4];
   logic [10:0] c_rp [4];
   always @(posedge clk) begin
      a_rp[0] <= a_read_ad;
      b_rp[0] <= b_read_ad;
      c_rp[0] <= c_read_ad;
      for (int i = 1; i < 4; i++) begin
         a_rp[i] <= a_rp[i-1];
         b_rp[i] <= b_rp[i-1];
         c_rp[i] <= c_rp[i-1];
      end
   end
   assign a_read_data = mem[a_rp[A_LAT-1]];
   assign b_read_data = mem[b_rp[B_LAT-1]];
   assign c_read_data = mem[c_rp[C_LAT-1]];

   // Cell index of a raster position, 0 when it lies outside the visible text grid.
   function automatic int cell_of(input cfg_t c, input int h, input int v);
      if (h < c.ha && v < c.va && h < 512 && v < 256) return (v / 8) * 64 + h / 8;
      return 0;
   endfunction

   // Expected outputs after `cnt` edges since release, from raster arithmetic on a pixel index.
   function automatic exp_t model(input cfg_t c, input int cnt);
      exp_t e;
      int ht, vt, p, h, v, hsa, vsa;
      ht = c.ha + c.hf + c.hs + c.hb;
      vt = c.va + c.vf + c.vs + c.vb;
      e = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      e.hs = (c.pol == 0) ? 1 : 0;
      e.vs = e.hs;
      if (cnt >= 1) begin
         p = cnt - 1;
         e.ad = cell_of(c, p % ht, (p / ht) % vt);
      end
      if (cnt >= c.lat + 1) begin
         p = cnt - 1 - c.lat;
         h = p % ht;
         v = (p / ht) % vt;
         hsa  = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? 1 : 0;
         vsa  = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? 1 : 0;
         e.hs = (hsa == c.pol) ? 1 : 0;
         e.vs = (vsa == c.pol) ? 1 : 0;
         e.de = (h < c.ha && v < c.va) ? 1 : 0;
         e.it = (e.de == 1 && h < 512 && v < 256) ? 1 : 0;
         e.fs = (h == 0 && v == 0) ? 1 : 0;
         e.px = h % 8;
         e.py = v % 8;
         e.cd = (e.it == 1) ? int'(mem[cell_of(c, h, v)]) : 0;
      end
      return e;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s (n=%0d): got %0d, expected %0d", nm, n, act, exp);
      end
   endtask

   task automatic chk_inst(input string tag, input exp_t e, input int ad, input int hs,
                           input int vs, input int de, input int it, input int fs,
                           input int px, input int py, input int cd);
      chk({tag, " read_ad"},     ad, e.ad);
      chk({tag, " hsync"},       hs, e.hs);
      chk({tag, " vsync"},       vs, e.vs);
      chk({tag, " de"},          de, e.de);
      chk({tag, " in_text"},     it, e.it);
      chk({tag, " frame_start"}, fs, e.fs);
      chk({tag, " px_x"},        px, e.px);
      chk({tag, " px_y"},        py, e.py);
      chk({tag, " cell_data"},   cd, e.cd);
   endtask

   // One clock: sample every instance at the falling edge against the model.
   task automatic tick();
      @(negedge clk);
      chk_inst("A", model(cfg_a, n), int'(a_read_ad), int'(a_hsync), int'(a_vsync), int'(a_de),
               int'(a_in_text), int'(a_frame_start), int'(a_px_x), int'(a_px_y), int'(a_cell_data));
      chk_inst("B", model(cfg_b, n), int'(b_read_ad), int'(b_hsync), int'(b_vsync), int'(b_de),
               int'(b_in_text), int'(b_frame_start), int'(b_px_x), int'(b_px_y), int'(b_cell_data));
      chk_inst("C", model(cfg_c, n), int'(c_read_ad), int'(c_hsync), int'(c_vsync), int'(c_de),
               int'(c_in_text), int'(c_frame_start), int'(c_px_x), int'(c_px_y), int'(c_cell_data));
   endtask

   task automatic wait_n(input int target);
      int g;
      g = 0;
      while (n < target && g < 50000) begin
         tick();
         g++;
      end
      chk("edge count reached", n, target);
   endtask

   vec_t tbl [22];
   int run;

   initial begin
      // Hand-derived vectors for instance A (H 16/2/2/2, V 16/1/1/1, RD_LAT 2), identity RAM.
      //          n   ad hs vs de it fs px py cd
      tbl[0]  = '{  1,  0, 1, 1, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{  2,  0, 1, 1, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{  3,  0, 1, 1, 1, 1, 1, 0, 0, 0};
      tbl[3]  = '{  4,  0, 1, 1, 1, 1, 0, 1, 0, 0};
      tbl[4]  = '{ 10,  1, 1, 1, 1, 1, 0, 7, 0, 0};
      tbl[5]  = '{ 11,  1, 1, 1, 1, 1, 0, 0, 0, 1};
      tbl[6]  = '{ 18,  0, 1, 1, 1, 1, 0, 7, 0, 1};
      tbl[7]  = '{ 19,  0, 1, 1, 0, 0, 0, 0, 0, 0};
      tbl[8]  = '{ 21,  0, 0, 1, 0, 0, 0, 2, 0, 0};
      tbl[9]  = '{ 22,  0, 0, 1, 0, 0, 0, 3, 0, 0};
      tbl[10] = '{ 23,  0, 1, 1, 0, 0, 0, 4, 0, 0};
      tbl[11] = '{ 25,  0, 1, 1, 1, 1, 0, 0, 1, 0};
      tbl[12] = '{ 76,  1, 1, 1, 1, 1, 0, 7, 3, 0};
      tbl[13] = '{177, 64, 1, 1, 0, 0, 0, 4, 7, 0};
      tbl[14] = '{185, 65, 1, 1, 1, 1, 0, 6, 0, 64};
      tbl[15] = '{187, 65, 1, 1, 1, 1, 0, 0, 0, 65};
      tbl[16] = '{214, 65, 1, 1, 1, 1, 0, 5, 1, 65};
      tbl[17] = '{376,  0, 1, 1, 0, 0, 0, 5, 0, 0};
      tbl[18] = '{377,  0, 1, 0, 0, 0, 0, 0, 1, 0};
      tbl[19] = '{399,  0, 1, 1, 0, 0, 0, 0, 2, 0};
      tbl[20] = '{420,  0, 1, 1, 0, 0, 0, 5, 2, 0};
      tbl[21] = '{421,  0, 1, 1, 1, 1, 1, 0, 0, 0};

      reset = 1'b0;
      for (int i = 0; i < 2048; i++) mem[i] = 9'(i);
      repeat (5) tick();
      chk("rst A hsync", int'(a_hsync), 1);
      chk("rst B hsync", int'(b_hsync), 0);
      chk("rst B vsync", int'(b_vsync), 0);
      chk("rst A de", int'(a_de), 0);
      chk("rst C read_ad", int'(c_read_ad), 0);
      @(posedge clk);
      #3 reset = 1'b1;

      for (int k = 0; k < 22; k++) begin
         wait_n(tbl[k].n);
         chk($sformatf("tbl%0d read_ad", k),     int'(a_read_ad),     tbl[k].ad);
         chk($sformatf("tbl%0d hsync", k),       int'(a_hsync),       tbl[k].hs);
         chk($sformatf("tbl%0d vsync", k),       int'(a_vsync),       tbl[k].vs);
         chk($sformatf("tbl%0d de", k),          int'(a_de),          tbl[k].de);
         chk($sformatf("tbl%0d in_text", k),     int'(a_in_text),     tbl[k].it);
         chk($sformatf("tbl%0d frame_start", k), int'(a_frame_start), tbl[k].fs);
         chk($sformatf("tbl%0d px_x", k),        int'(a_px_x),        tbl[k].px);
         chk($sformatf("tbl%0d px_y", k),        int'(a_px_y),        tbl[k].py);
         chk($sformatf("tbl%0d cell_data", k),   int'(a_cell_data),   tbl[k].cd);
      end

      // Grid overflow on B (H_ACTIVE 520, RD_LAT 3, active-high sync).
      wait_n(512); chk("B last grid col read_ad", int'(b_read_ad), 63);
      wait_n(513); chk("B overflow read_ad", int'(b_read_ad), 0);
      wait_n(515); chk("B col511 in_text", int'(b_in_text), 1);
                   chk("B col511 cell_data", int'(b_cell_data), 63);
      wait_n(516); chk("B h512 de", int'(b_de), 1);
                   chk("B h512 in_text", int'(b_in_text), 0);
                   chk("B h512 cell_data", int'(b_cell_data), 0);
      wait_n(523); chk("B h519 de", int'(b_de), 1);
                   chk("B h519 cell_data", int'(b_cell_data), 0);
      wait_n(524); chk("B h520 de", int'(b_de), 0);
      wait_n(531); chk("B pre-sync hsync", int'(b_hsync), 0);
      wait_n(532); chk("B sync hsync", int'(b_hsync), 1);

      // Mid-frame asynchronous reset for one cycle.
      wait_n(2000);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("mid rst A read_ad", int'(a_read_ad), 0);
      chk("mid rst A de", int'(a_de), 0);
      chk("mid rst A hsync", int'(a_hsync), 1);
      chk("mid rst A vsync", int'(a_vsync), 1);
      chk("mid rst C cell_data", int'(c_cell_data), 0);
      chk("mid rst C in_text", int'(c_in_text), 0);
      chk("mid rst B hsync", int'(b_hsync), 0);
      chk("mid rst B px_x", int'(b_px_x), 0);
      @(posedge clk);
      #3 reset = 1'b1;
      wait_n(2); chk("restart A fs early", int'(a_frame_start), 0);
                 chk("restart C fs", int'(c_frame_start), 1);
      wait_n(3); chk("restart A fs", int'(a_frame_start), 1);
      wait_n(4); chk("restart B fs", int'(b_frame_start), 1);

      // Random RAM contents, random run lengths and reset placement.
      for (int it = 0; it < 4; it++) begin
         @(posedge clk);
         #($urandom_range(1, 4)) reset = 1'b0;
         for (int i = 0; i < 2048; i++) mem[i] = 9'($urandom);
         repeat ($urandom_range(1, 3)) tick();
         @(posedge clk);
         #3 reset = 1'b1;
         run = $urandom_range(600, 5000);
         repeat (run) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
